// File: rtl/c7bbiu_rd_arb.sv
// c7bbiu_rd_arb: round-robin read-request arbiter in front of the BIU AXI read interface,
// one pending slot and one outstanding read per requester (IFU, LSU, ICU), with watchdog.
module c7bbiu_rd_arb #(
    parameter logic [3:0] RID_IFU = 4'd0,
    parameter logic [3:0] RID_LSU = 4'd1,
    parameter logic [3:0] RID_ICU = 4'd2,
    parameter int         TMO_W   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_biu_rd_val,
    input  logic [31:0] ifu_biu_rd_addr,
    output logic        biu_ifu_rd_rdy,
    input  logic        lsu_biu_rd_val,
    input  logic [31:0] lsu_biu_rd_addr,
    input  logic [2:0]  lsu_biu_rd_size,
    output logic        biu_lsu_rd_rdy,
    input  logic        icu_biu_rd_val,
    input  logic [31:0] icu_biu_rd_addr,
    output logic        biu_icu_rd_rdy,
    input  logic        axi_ar_ready,
    output logic        arb_rd_val,
    output logic [3:0]  arb_rd_id,
    output logic [31:0] arb_rd_addr,
    output logic [1:0]  arb_rd_burst,
    output logic [7:0]  arb_rd_len,
    output logic [2:0]  arb_rd_size,
    output logic        arb_rd_lock,
    output logic [3:0]  arb_rd_cache,
    output logic [2:0]  arb_rd_prot,
    input  logic        axi_rdata_ifu_val,
    input  logic        axi_rdata_lsu_val,
    input  logic        axi_rdata_icu_val,
    input  logic        axi_rdata_last,
    output logic        biu_ifu_rd_err,
    output logic        biu_lsu_rd_err,
    output logic        biu_icu_rd_err
);
    logic [2:0]       pend_q, pend_d, outst_q, outst_d;
    logic [2:0]       val, rdy, comp, expire, gnt;
    logic [1:0]       ptr_q, ptr_d, nxt1, nxt2, win;
    logic [31:0]      ifu_addr_q, ifu_addr_d, lsu_addr_q, lsu_addr_d, icu_addr_q, icu_addr_d;
    logic [2:0]       lsu_size_q, lsu_size_d;
    logic [TMO_W-1:0] cnt_q [3];
    logic [TMO_W-1:0] cnt_d [3];
    logic             issue;

    assign val  = {icu_biu_rd_val, lsu_biu_rd_val, ifu_biu_rd_val};
    assign rdy  = ~pend_q & ~outst_q;
    assign comp = outst_q & {axi_rdata_icu_val & axi_rdata_last, axi_rdata_lsu_val, axi_rdata_ifu_val};
    assign {biu_icu_rd_rdy, biu_lsu_rd_rdy, biu_ifu_rd_rdy} = rdy;
    assign {biu_icu_rd_err, biu_lsu_rd_err, biu_ifu_rd_err} = expire;

    // Search one and two places past the last grant; the last grant itself comes last.
    assign nxt1  = (ptr_q == 2'd0) ? 2'd1 : (ptr_q == 2'd1) ? 2'd2 : 2'd0;
    assign nxt2  = (ptr_q == 2'd0) ? 2'd2 : (ptr_q == 2'd1) ? 2'd0 : 2'd1;
    assign win   = pend_q[nxt1] ? nxt1 : pend_q[nxt2] ? nxt2 : ptr_q;
    assign issue = |pend_q & axi_ar_ready;
    assign gnt   = {3{issue}} & {win == 2'd2, win == 2'd1, win == 2'd0};

    assign arb_rd_val   = issue;
    assign arb_rd_id    = gnt[0] ? RID_IFU : gnt[1] ? RID_LSU : gnt[2] ? RID_ICU : 4'd0;
    assign arb_rd_addr  = ({32{gnt[0]}} & ifu_addr_q) | ({32{gnt[1]}} & lsu_addr_q) |
                          ({32{gnt[2]}} & icu_addr_q);
    assign arb_rd_len   = gnt[2] ? 8'd3 : 8'd0;
    assign arb_rd_size  = gnt[1] ? lsu_size_q : (gnt[0] | gnt[2]) ? 3'd3 : 3'd0;
    assign arb_rd_burst = issue ? 2'b01 : 2'b00;
    assign arb_rd_lock  = 1'b0;
    assign arb_rd_cache = 4'b0000;
    assign arb_rd_prot  = (gnt[0] | gnt[2]) ? 3'b100 : 3'b000;

    always_comb begin
        pend_d     = pend_q;
        outst_d    = outst_q;
        expire     = '0;
        ptr_d      = issue ? win : ptr_q;
        ifu_addr_d = (val[0] & rdy[0]) ? ifu_biu_rd_addr : ifu_addr_q;
        lsu_addr_d = (val[1] & rdy[1]) ? lsu_biu_rd_addr : lsu_addr_q;
        lsu_size_d = (val[1] & rdy[1]) ? lsu_biu_rd_size : lsu_size_q;
        icu_addr_d = (val[2] & rdy[2]) ? (icu_biu_rd_addr & 32'hFFFF_FFE0) : icu_addr_q;
        for (int i = 0; i < 3; i++) begin
            // the count names the cycles spent outstanding; reaching all-ones is the timeout
            cnt_d[i]  = outst_q[i] ? cnt_q[i] + 1'b1 : '0;
            expire[i] = outst_q[i] & (&cnt_d[i]) & ~comp[i];
            if (comp[i] | expire[i])
                outst_d[i] = 1'b0;
            if (val[i] & rdy[i])
                pend_d[i] = 1'b1;
            if (gnt[i]) begin
                pend_d[i]  = 1'b0;
                outst_d[i] = 1'b1;
                cnt_d[i]   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            outst_q    <= '0;
            ptr_q      <= 2'd2;
            ifu_addr_q <= '0;
            lsu_addr_q <= '0;
            icu_addr_q <= '0;
            lsu_size_q <= '0;
            cnt_q      <= '{default: '0};
        end else begin
            pend_q     <= pend_d;
            outst_q    <= outst_d;
            ptr_q      <= ptr_d;
            ifu_addr_q <= ifu_addr_d;
            lsu_addr_q <= lsu_addr_d;
            icu_addr_q <= icu_addr_d;
            lsu_size_q <= lsu_size_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_c7bbiu_rd_arb.sv
// tb_c7bbiu_rd_arb: directed scenarios plus randomized traffic checked against a
// per-requester state model of the read arbiter.
module tb_c7bbiu_rd_arb;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ifu_biu_rd_val, lsu_biu_rd_val, icu_biu_rd_val, axi_ar_ready;
    logic [31:0] ifu_biu_rd_addr, lsu_biu_rd_addr, icu_biu_rd_addr;
    logic [2:0]  lsu_biu_rd_size;
    logic        axi_rdata_ifu_val, axi_rdata_lsu_val, axi_rdata_icu_val, axi_rdata_last;
    logic        biu_ifu_rd_rdy, biu_lsu_rd_rdy, biu_icu_rd_rdy;
    logic        biu_ifu_rd_err, biu_lsu_rd_err, biu_icu_rd_err;
    logic        arb_rd_val, arb_rd_lock;
    logic [3:0]  arb_rd_id, arb_rd_cache;
    logic [31:0] arb_rd_addr;
    logic [1:0]  arb_rd_burst;
    logic [7:0]  arb_rd_len;
    logic [2:0]  arb_rd_size, arb_rd_prot;
    logic [57:0] ar_bus;
    logic [2:0]  rdy_v, err_v;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    c7bbiu_rd_arb dut (
        .clk(clk), .reset(reset),
        .ifu_biu_rd_val(ifu_biu_rd_val), .ifu_biu_rd_addr(ifu_biu_rd_addr), .biu_ifu_rd_rdy(biu_ifu_rd_rdy),
        .lsu_biu_rd_val(lsu_biu_rd_val), .lsu_biu_rd_addr(lsu_biu_rd_addr), .lsu_biu_rd_size(lsu_biu_rd_size),
        .biu_lsu_rd_rdy(biu_lsu_rd_rdy),
        .icu_biu_rd_val(icu_biu_rd_val), .icu_biu_rd_addr(icu_biu_rd_addr), .biu_icu_rd_rdy(biu_icu_rd_rdy),
        .axi_ar_ready(axi_ar_ready), .arb_rd_val(arb_rd_val), .arb_rd_id(arb_rd_id), .arb_rd_addr(arb_rd_addr),
        .arb_rd_burst(arb_rd_burst), .arb_rd_len(arb_rd_len), .arb_rd_size(arb_rd_size),
        .arb_rd_lock(arb_rd_lock), .arb_rd_cache(arb_rd_cache), .arb_rd_prot(arb_rd_prot),
        .axi_rdata_ifu_val(axi_rdata_ifu_val), .axi_rdata_lsu_val(axi_rdata_lsu_val),
        .axi_rdata_icu_val(axi_rdata_icu_val), .axi_rdata_last(axi_rdata_last),
        .biu_ifu_rd_err(biu_ifu_rd_err), .biu_lsu_rd_err(biu_lsu_rd_err), .biu_icu_rd_err(biu_icu_rd_err)
    );

    assign ar_bus = {arb_rd_val, arb_rd_id, arb_rd_addr, arb_rd_len, arb_rd_size, arb_rd_burst,
                     arb_rd_prot, arb_rd_lock, arb_rd_cache};
    assign rdy_v  = {biu_icu_rd_rdy, biu_lsu_rd_rdy, biu_ifu_rd_rdy};
    assign err_v  = {biu_icu_rd_err, biu_lsu_rd_err, biu_ifu_rd_err};

    // Reference model: st 0=free 1=pending 2=outstanding; age = cycles since issue.
    int          st [3];
    int          age [3];
    int          last_g;
    int          w;
    logic [31:0] m_addr [3];
    logic [2:0]  m_size [3];
    logic [31:0] ain [3];
    logic [2:0]  vin, strb, e_rdy, e_err, e_done;
    logic [57:0] e_bus;

    assign ain[0] = ifu_biu_rd_addr;
    assign ain[1] = lsu_biu_rd_addr;
    assign ain[2] = icu_biu_rd_addr;
    assign vin    = {icu_biu_rd_val, lsu_biu_rd_val, ifu_biu_rd_val};
    assign strb   = {axi_rdata_icu_val & axi_rdata_last, axi_rdata_lsu_val, axi_rdata_ifu_val};

    always_comb begin
        w = -1;
        for (int k = 1; k <= 3; k++)
            if (w < 0 && st[(last_g + k) % 3] == 1) w = (last_g + k) % 3;
        e_bus = '0;
        if (w >= 0 && axi_ar_ready)
            e_bus = {1'b1, 4'(w), m_addr[w], (w == 2) ? 8'd3 : 8'd0, m_size[w], 2'b01,
                     (w == 1) ? 3'b000 : 3'b100, 1'b0, 4'b0000};
        e_rdy  = '0;
        e_done = '0;
        e_err  = '0;
        for (int i = 0; i < 3; i++) begin
            e_rdy[i]  = (st[i] == 0);
            e_done[i] = (st[i] == 2) && strb[i];
            e_err[i]  = (st[i] == 2) && (age[i] == 1023) && !e_done[i];
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                st[i]  <= 0;
                age[i] <= 0;
            end
            last_g <= 2;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (st[i] == 2) begin
                    if (e_done[i] || e_err[i]) st[i] <= 0;
                    else age[i] <= age[i] + 1;
                end else if (st[i] == 0 && vin[i]) begin
                    st[i]     <= 1;
                    m_addr[i] <= (i == 2) ? (ain[i] & 32'hFFFF_FFE0) : ain[i];
                    m_size[i] <= (i == 1) ? lsu_biu_rd_size : 3'd3;
                end
            end
            if (e_bus[57]) begin
                st[w]  <= 2;
                age[w] <= 1;
                last_g <= w;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_biu_rd_val = 0; lsu_biu_rd_val = 0; icu_biu_rd_val = 0; axi_ar_ready = 0;
        ifu_biu_rd_addr = 0; lsu_biu_rd_addr = 0; icu_biu_rd_addr = 0; lsu_biu_rd_size = 0;
        axi_rdata_ifu_val = 0; axi_rdata_lsu_val = 0; axi_rdata_icu_val = 0; axi_rdata_last = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        axi_ar_ready = 1;
        #1 reset = 1'b1;
        #2;
        checks++; if (ar_bus !== '0) begin errors++; $display("FAIL reset_bus: got %h expected 0", ar_bus); end
        checks++; if (rdy_v !== 3'b111) begin errors++; $display("FAIL reset_rdy: got %b expected 111", rdy_v); end
        checks++; if (err_v !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", err_v); end
        #3 reset = 1'b0;
        @(negedge clk);
        checks++; if (rdy_v !== 3'b111) begin errors++; $display("FAIL reset_rdy_after: got %b expected 111", rdy_v); end
    endtask

    task automatic test_single_ifu();
        do_reset();
        nxt(); ifu_biu_rd_val = 1; ifu_biu_rd_addr = 32'h1000_0004; axi_ar_ready = 1;
        @(negedge clk);
        checks++; if (ar_bus !== '0) begin errors++; $display("FAIL ifu_no_early_issue: got %h expected 0", ar_bus); end
        nxt(); ifu_biu_rd_val = 0;
        @(negedge clk);
        checks++;
        if (ar_bus !== {1'b1, 4'd0, 32'h1000_0004, 8'd0, 3'd3, 2'b01, 3'b100, 1'b0, 4'd0}) begin
            errors++; $display("FAIL ifu_issue: got %h expected %h", ar_bus,
                               {1'b1, 4'd0, 32'h1000_0004, 8'd0, 3'd3, 2'b01, 3'b100, 1'b0, 4'd0});
        end
        checks++; if (biu_ifu_rd_rdy !== 1'b0) begin errors++; $display("FAIL ifu_rdy_pend: got %b expected 0", biu_ifu_rd_rdy); end
        nxt(); @(negedge clk);
        checks++; if ({arb_rd_val, biu_ifu_rd_rdy} !== 2'b00) begin
            errors++; $display("FAIL ifu_outst: got val,rdy=%b expected 00", {arb_rd_val, biu_ifu_rd_rdy}); end
        nxt(); axi_rdata_ifu_val = 1;
        @(negedge clk);
        checks++; if (biu_ifu_rd_rdy !== 1'b0) begin errors++; $display("FAIL ifu_rdy_beat: got %b expected 0", biu_ifu_rd_rdy); end
        nxt(); axi_rdata_ifu_val = 0;
        @(negedge clk);
        checks++; if (biu_ifu_rd_rdy !== 1'b1) begin errors++; $display("FAIL ifu_rdy_done: got %b expected 1", biu_ifu_rd_rdy); end
    endtask

    task automatic test_icu_refill();
        do_reset();
        nxt(); icu_biu_rd_val = 1; icu_biu_rd_addr = 32'h2000_001C; axi_ar_ready = 1;
        nxt(); icu_biu_rd_val = 0;
        @(negedge clk);
        checks++;
        if (ar_bus !== {1'b1, 4'd2, 32'h2000_0000, 8'd3, 3'd3, 2'b01, 3'b100, 1'b0, 4'd0}) begin
            errors++; $display("FAIL icu_issue: got %h expected %h", ar_bus,
                               {1'b1, 4'd2, 32'h2000_0000, 8'd3, 3'd3, 2'b01, 3'b100, 1'b0, 4'd0});
        end
        for (int b = 0; b < 4; b++) begin
            nxt(); axi_rdata_icu_val = 1; axi_rdata_last = (b == 3);
            nxt(); axi_rdata_icu_val = 0; axi_rdata_last = 0;
            @(negedge clk);
            checks++; if (biu_icu_rd_rdy !== (b == 3)) begin
                errors++; $display("FAIL icu_rdy_beat%0d: got %b expected %b", b + 1, biu_icu_rd_rdy, b == 3); end
        end
    endtask

    task automatic test_contention();
        do_reset();
        nxt(); ifu_biu_rd_val = 1; ifu_biu_rd_addr = 32'h0000_0100;
        lsu_biu_rd_val = 1; lsu_biu_rd_addr = 32'h0000_0200; lsu_biu_rd_size = 3'd1;
        icu_biu_rd_val = 1; icu_biu_rd_addr = 32'h0000_0300; axi_ar_ready = 1;
        nxt(); ifu_biu_rd_val = 0; lsu_biu_rd_val = 0; icu_biu_rd_val = 0;
        @(negedge clk);
        checks++; if ({arb_rd_val, arb_rd_id} !== 5'h10) begin errors++; $display("FAIL cont_first: got %h expected 10", {arb_rd_val, arb_rd_id}); end
        nxt(); axi_rdata_ifu_val = 1;
        @(negedge clk);
        checks++; if ({arb_rd_val, arb_rd_id} !== 5'h11) begin errors++; $display("FAIL cont_second: got %h expected 11", {arb_rd_val, arb_rd_id}); end
        nxt(); axi_rdata_ifu_val = 0; axi_ar_ready = 0; ifu_biu_rd_val = 1; ifu_biu_rd_addr = 32'h0000_0400;
        @(negedge clk);
        checks++; if ({arb_rd_val, biu_ifu_rd_rdy} !== 2'b01) begin
            errors++; $display("FAIL cont_hold: got val,rdy=%b expected 01", {arb_rd_val, biu_ifu_rd_rdy}); end
        nxt(); ifu_biu_rd_val = 0; axi_ar_ready = 1;
        @(negedge clk);
        checks++; if ({arb_rd_val, arb_rd_id} !== 5'h12) begin errors++; $display("FAIL cont_icu_before_ifu: got %h expected 12", {arb_rd_val, arb_rd_id}); end
        nxt(); @(negedge clk);
        checks++;
        if (ar_bus !== {1'b1, 4'd0, 32'h0000_0400, 8'd0, 3'd3, 2'b01, 3'b100, 1'b0, 4'd0}) begin
            errors++; $display("FAIL cont_ifu_again: got %h expected %h", ar_bus,
                               {1'b1, 4'd0, 32'h0000_0400, 8'd0, 3'd3, 2'b01, 3'b100, 1'b0, 4'd0});
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        nxt(); lsu_biu_rd_val = 1; lsu_biu_rd_addr = 32'h3000_0042; lsu_biu_rd_size = 3'd2; axi_ar_ready = 0;
        nxt(); lsu_biu_rd_val = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (ar_bus !== '0) begin errors++; $display("FAIL bp_hold%0d: got %h expected 0", c, ar_bus); end
            nxt();
        end
        axi_ar_ready = 1;
        @(negedge clk);
        checks++;
        if (ar_bus !== {1'b1, 4'd1, 32'h3000_0042, 8'd0, 3'd2, 2'b01, 3'b000, 1'b0, 4'd0}) begin
            errors++; $display("FAIL bp_release: got %h expected %h", ar_bus,
                               {1'b1, 4'd1, 32'h3000_0042, 8'd0, 3'd2, 2'b01, 3'b000, 1'b0, 4'd0});
        end
    endtask

    task automatic test_watchdog();
        int n;
        bit got;
        do_reset();
        nxt(); lsu_biu_rd_val = 1; lsu_biu_rd_addr = 32'h4000_0010; lsu_biu_rd_size = 3'd2; axi_ar_ready = 1;
        nxt(); lsu_biu_rd_val = 0;
        @(negedge clk);
        checks++; if ({arb_rd_val, arb_rd_id} !== 5'h11) begin errors++; $display("FAIL wd_issue: got %h expected 11", {arb_rd_val, arb_rd_id}); end
        n = 0;
        got = 0;
        while (n < 1100 && !got) begin
            nxt(); n++;
            @(negedge clk);
            if (err_v !== 3'b000) got = 1;
        end
        checks++; if (!got || n != 1023 || err_v !== 3'b010) begin
            errors++; $display("FAIL wd_err: got err=%b after %0d cycles expected 010 after 1023", err_v, n); end
        checks++; if (biu_lsu_rd_rdy !== 1'b0) begin errors++; $display("FAIL wd_rdy_at_err: got %b expected 0", biu_lsu_rd_rdy); end
        nxt(); @(negedge clk);
        checks++; if ({err_v, biu_lsu_rd_rdy} !== 4'b0001) begin
            errors++; $display("FAIL wd_after: got err,rdy=%b expected 0001", {err_v, biu_lsu_rd_rdy}); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        nxt(); ifu_biu_rd_val = 1; ifu_biu_rd_addr = 32'h5000_0000; axi_ar_ready = 1;
        nxt(); ifu_biu_rd_val = 0;
        nxt(); icu_biu_rd_val = 1; icu_biu_rd_addr = 32'h6000_0020; axi_ar_ready = 0;
        nxt(); icu_biu_rd_val = 0;
        @(negedge clk);
        checks++; if (rdy_v !== 3'b010) begin errors++; $display("FAIL mid_pre: got %b expected 010", rdy_v); end
        #1 axi_ar_ready = 1; reset = 1'b1;
        #1;
        checks++; if ({rdy_v, ar_bus} !== {3'b111, 58'd0}) begin
            errors++; $display("FAIL mid_async: got rdy=%b bus=%h expected 111/0", rdy_v, ar_bus); end
        #1 reset = 1'b0;
        nxt(); axi_rdata_ifu_val = 1;
        @(negedge clk);
        checks++; if ({rdy_v, err_v, ar_bus} !== {3'b111, 3'b000, 58'd0}) begin
            errors++; $display("FAIL mid_late_beat: got rdy=%b err=%b bus=%h expected 111/000/0", rdy_v, err_v, ar_bus); end
        nxt(); axi_rdata_ifu_val = 0;
        @(negedge clk);
        checks++; if ({rdy_v, ar_bus} !== {3'b111, 58'd0}) begin
            errors++; $display("FAIL mid_after: got rdy=%b bus=%h expected 111/0", rdy_v, ar_bus); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            nxt();
            ifu_biu_rd_val    = 1'($urandom_range(0, 1));
            lsu_biu_rd_val    = 1'($urandom_range(0, 1));
            icu_biu_rd_val    = 1'($urandom_range(0, 1));
            ifu_biu_rd_addr   = $urandom;
            lsu_biu_rd_addr   = $urandom;
            icu_biu_rd_addr   = $urandom;
            lsu_biu_rd_size   = 3'($urandom_range(0, 3));
            axi_ar_ready      = ($urandom_range(0, 3) != 0);
            axi_rdata_ifu_val = ($urandom_range(0, 3) == 0);
            axi_rdata_lsu_val = ($urandom_range(0, 3) == 0);
            axi_rdata_icu_val = ($urandom_range(0, 2) == 0);
            axi_rdata_last    = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if (ar_bus !== e_bus) begin errors++; $display("FAIL rnd_bus c%0d: got %h expected %h", c, ar_bus, e_bus); end
            checks++; if (rdy_v !== e_rdy) begin errors++; $display("FAIL rnd_rdy c%0d: got %b expected %b", c, rdy_v, e_rdy); end
            checks++; if (err_v !== e_err) begin errors++; $display("FAIL rnd_err c%0d: got %b expected %b", c, err_v, e_err); end
        end
        nxt();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_ifu();
        test_icu_refill();
        test_contention();
        test_backpressure();
        test_watchdog();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/c7bbiu_rd_arb.md
Name: c7bbiu_rd_arb

Overview:
- Read-request arbiter directly upstream of the BIU AXI interface.
- Accepts single-beat fetch reads from IFU, single-beat data reads from LSU and 4-beat line refills from ICU.
- Holds each request in a one-entry pending slot and selects one per cycle round-robin. Drives the arb_rd_* bus only when axi_ar_ready=1, so no request is dropped.
- Tracks one outstanding read per requester until its last R beat returns, or until a watchdog expires.

Parameters:
- RID_IFU, 4'd0, AR id for IFU reads; must equal the team's IFU read-id constant.
- RID_LSU, 4'd1, AR id for LSU reads.
- RID_ICU, 4'd2, AR id for ICU refills.
- TMO_W, 10, watchdog counter width; timeout = 2^TMO_W-1 cycles.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ifu_biu_rd_val  in  1  IFU request valid
- ifu_biu_rd_addr  in  32  IFU address
- biu_ifu_rd_rdy  out  1  IFU slot free
- lsu_biu_rd_val  in  1  LSU request valid
- lsu_biu_rd_addr  in  32  LSU address
- lsu_biu_rd_size  in  3  LSU AXI size
- biu_lsu_rd_rdy  out  1  LSU slot free
- icu_biu_rd_val  in  1  ICU refill valid
- icu_biu_rd_addr  in  32  ICU line address
- biu_icu_rd_rdy  out  1  ICU slot free
- axi_ar_ready  in  1  AXI interface can take a request this cycle
- arb_rd_val  out  1  request issue pulse
- arb_rd_id  out  4  AR id
- arb_rd_addr  out  32  AR address
- arb_rd_burst  out  2  AR burst type
- arb_rd_len  out  8  AR beat count minus 1
- arb_rd_size  out  3  AR beat size
- arb_rd_lock  out  1  AR lock
- arb_rd_cache  out  4  AR cache attributes
- arb_rd_prot  out  3  AR protection
- axi_rdata_ifu_val / axi_rdata_lsu_val / axi_rdata_icu_val  in  1 each  R-beat strobes from the AXI interface
- axi_rdata_last  in  1  last-beat flag
- biu_ifu_rd_err / biu_lsu_rd_err / biu_icu_rd_err  out  1 each  watchdog-expiry pulse

Behaviour:
- Per-requester state X ∈ {IFU, LSU, ICU}: FREE → PEND → OUTST → FREE. Encoded as pend_X and outst_X flops, all 0 at reset.
- Ready: biu_X_rd_rdy = ~pend_X & ~outst_X. It is purely registered state.
- Capture: when X_biu_rd_val & biu_X_rd_rdy, latch the fields at the clock edge and go to PEND. Val while not ready is ignored; the requester must hold val until it sees rdy.
- Captured fields by requester:
  - IFU: addr, len 0, size 3, prot 3'b100.
  - LSU: addr, lsu size, len 0, prot 3'b000.
  - ICU: {addr[31:5],5'b0}, len 3, size 3, prot 3'b100.
  - All requesters: burst 2'b01, lock 0, cache 4'b0000.
- Select: combinational round-robin over pend_*. Order starts after the last-granted requester; order IFU→LSU→ICU→IFU. Last-grant pointer resets to ICU, so IFU wins first.
- Issue:
  - arb_rd_val = any pend & axi_ar_ready.
  - arb_rd_* carry the winner's fields when arb_rd_val=1, else all-zero.
  - On issue: winner goes PEND→OUTST, pointer updates, watchdog clears.
  - axi_ar_ready=0 means no issue, no pointer move, and pending is retained.
- Completion:
  - IFU clears OUTST on axi_rdata_ifu_val.
  - LSU clears OUTST on axi_rdata_lsu_val.
  - ICU clears OUTST on axi_rdata_icu_val & axi_rdata_last; non-last ICU beats have no effect.
  - rdy rises the cycle after completion; no same-cycle re-accept.
- Watchdog: a per-requester TMO_W-bit counter increments each cycle in OUTST. At all-ones it forces FREE and pulses biu_X_rd_err for 1 cycle. This covers error responses, which are never strobed as rdata_val. A completion in the same cycle wins; there is then no err pulse.
- Latency: a request captured at edge N can appear as arb_rd_val in the cycle after edge N, at the earliest.
- Reset:
  - Asynchronous assertion clears all state immediately.
  - arb_rd_val=0, arb_rd_* = 0, rdy=1 (all), err=0.
  - Any in-flight request is abandoned; late R beats are ignored since OUTST=0.
- All three requesters can be OUTST concurrently; the AXI interface distinguishes them by id.

Test Plan:
- Single IFU: ifu val, addr 0x1000_0004, ar_ready=1 → next cycle arb_rd_val=1, id 0, addr 0x1000_0004, len 0, size 3, burst 1, prot 4; rdy_ifu=0 until axi_rdata_ifu_val, then 1 the following cycle.
- ICU refill: addr 0x2000_001C → arb addr 0x2000_0000, len 3, id 2. Beats 1-3 leave rdy_icu=0; beat 4 with last=1 sets rdy_icu=1 next cycle.
- Contention: IFU, LSU and ICU captured at the same edge, ar_ready=1 → issue order IFU, LSU, ICU on consecutive cycles. A new IFU request while ICU is pending issues after ICU.
- Backpressure: pending LSU with ar_ready=0 for 5 cycles → arb_rd_val=0 throughout. Issues in the first cycle ar_ready=1, with fields unchanged.
- Watchdog: LSU issued, no R beats → biu_lsu_rd_err pulses exactly 1023 cycles after issue; rdy_lsu=1 next cycle.
- Reset mid-flight: assert reset with IFU OUTST and ICU PEND → all rdy=1, arb_rd_val=0 immediately. A subsequent axi_rdata_ifu_val produces no state change.
